// File: rtl/gate_row_sequencer.sv
// Gate-driver row sequencer: walks the STV/CPV shift chain to a requested row, then gates OE.
// Optional GUARD phase before READY is enabled by defining GATE_SEQ_OE_GUARD_EN.
module gate_row_sequencer #(
  parameter int CPV_HALF = 50,
  parameter int MAX_ROWS = 3072,
  parameter int OE_GUARD = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        row_req,
  input  logic [11:0] row_addr,
  input  logic        gate_on,
  input  logic        abort,
  output logic        stv,
  output logic        cpv,
  output logic        oe,
  output logic        busy,
  output logic        row_ready,
  output logic        addr_err,
  output logic [11:0] cur_row
);

  localparam int CNT_MAX = (CPV_HALF > OE_GUARD) ? CPV_HALF : OE_GUARD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPV_HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    PULSE_HI,
    PULSE_LO,
`ifdef GATE_SEQ_OE_GUARD_EN
    GUARD,
`endif
    READY,
    DONE
  } state_t;

`ifdef GATE_SEQ_OE_GUARD_EN
  localparam logic [CW-1:0] GUARD_LAST   = CW'(OE_GUARD - 1);
  localparam state_t        AFTER_PULSES = GUARD;
`else
  localparam state_t        AFTER_PULSES = READY;
`endif

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [11:0]   pulse, pulse_next;
  logic [11:0]   target, target_next;
  logic [11:0]   cur_row_next;
  logic          seen, seen_next;
  logic          addr_ok;
  logic          phase_end;

  logic stv_d, cpv_d, oe_d, busy_d, row_ready_d, addr_err_d;

  assign addr_ok   = {1'b0, row_addr} < 13'(MAX_ROWS);
  assign phase_end = (cnt == HALF_LAST);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse   <= '0;
      target  <= '0;
      seen    <= 1'b0;
      cur_row <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pulse   <= pulse_next;
      target  <= target_next;
      seen    <= seen_next;
      cur_row <= cur_row_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (row_req && !abort && addr_ok) state_next = START;
      START:    if (phase_end) state_next = PULSE_HI;
      PULSE_HI: if (phase_end) state_next = PULSE_LO;
      PULSE_LO: if (phase_end) state_next = (pulse == target) ? AFTER_PULSES : PULSE_HI;
`ifdef GATE_SEQ_OE_GUARD_EN
      GUARD:    if (cnt == GUARD_LAST) state_next = READY;
`endif
      READY:    if (seen && !gate_on) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (abort && state != IDLE) state_next = IDLE;

    // Phase counter restarts on every state change; untimed states keep it at zero
    if (state_next != state || state == IDLE || state == READY || state == DONE)
      cnt_next = '0;
    else
      cnt_next = cnt + CW'(1);

    pulse_next   = pulse;
    target_next  = target;
    cur_row_next = cur_row;
    if (state == IDLE && state_next == START) begin
      pulse_next  = '0;
      target_next = row_addr;
    end
    if (state == PULSE_LO && state_next == PULSE_HI) pulse_next = pulse + 12'd1;
    if (state == PULSE_HI && state_next == PULSE_LO) cur_row_next = pulse;

    seen_next = (state == READY) ? (seen | gate_on) : 1'b0;
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    busy_d      = (state_next != IDLE);
    stv_d       = (state_next == START) || (state_next == PULSE_HI && pulse_next == 12'd0);
    cpv_d       = (state_next == PULSE_HI);
    row_ready_d = (state_next == READY);
    oe_d        = (state_next == READY) && gate_on;
    addr_err_d  = (state == IDLE) && row_req && !abort && !addr_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stv       <= 1'b0;
      cpv       <= 1'b0;
      oe        <= 1'b0;
      busy      <= 1'b0;
      row_ready <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      stv       <= stv_d;
      cpv       <= cpv_d;
      oe        <= oe_d;
      busy      <= busy_d;
      row_ready <= row_ready_d;
      addr_err  <= addr_err_d;
    end
  end

endmodule

// File: doc/gate_row_sequencer.md
GATE_ROW_SEQUENCER -- requirements
Module: gate_row_sequencer

Interface
REQ-001 The block SHALL have parameter CPV_HALF, default 50: CPV half-period in clk cycles, legal range >= 2.
REQ-002 The block SHALL have parameter MAX_ROWS, default 3072: number of gate lines, legal range <= 4096.
REQ-003 The block SHALL have parameter OE_GUARD, default 20: OE guard time in clk cycles, used only when GATE_SEQ_OE_GUARD_EN is defined.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port row_req, input, 1 bit: single-cycle request to position the gate chain at row_addr.
REQ-007 The block SHALL have port row_addr, input, 12 bits: target row, sampled with row_req.
REQ-008 The block SHALL have port gate_on, input, 1 bit: level request to open the selected row (the upstream reset pulse).
REQ-009 The block SHALL have port abort, input, 1 bit: level; terminates any operation in progress.
REQ-010 The block SHALL have port stv, output, 1 bit: gate driver start-vertical.
REQ-011 The block SHALL have port cpv, output, 1 bit: gate driver shift clock.
REQ-012 The block SHALL have port oe, output, 1 bit: gate driver output enable.
REQ-013 The block SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-014 The block SHALL have port row_ready, output, 1 bit: high while the chain sits on the target row.
REQ-015 The block SHALL have port addr_err, output, 1 bit: one-cycle pulse on an out-of-range request.
REQ-016 The block SHALL have port cur_row, output, 12 bits: row currently latched in the gate chain.

Function
REQ-017 All outputs SHALL be registered; the cycle in which row_req is sampled is cycle 0, and H denotes CPV_HALF.
REQ-018 The FSM SHALL have states IDLE, START, PULSE_HI, PULSE_LO, GUARD, READY and DONE.
REQ-019 In IDLE, row_req with row_addr < MAX_ROWS SHALL latch target N = row_addr and enter START; busy and stv SHALL go high from cycle 1.
REQ-020 In IDLE, row_req with row_addr >= MAX_ROWS SHALL assert addr_err for exactly cycle 1 and remain in IDLE with busy = 0.
REQ-021 row_req received while not in IDLE SHALL be ignored, with no addr_err.
REQ-022 START SHALL last H cycles with stv = 1 and cpv = 0.
REQ-023 The sequencer SHALL then issue exactly N+1 cpv pulses, each H cycles high (PULSE_HI) followed by H cycles low (PULSE_LO); pulse k SHALL go high at cycle 1+H+2kH.
REQ-024 stv SHALL stay high through the high phase of pulse 0 and be low from cycle 2H+1, giving 2H cycles of stv.
REQ-025 cur_row SHALL be 0 after the falling edge of pulse 0 and SHALL increment by 1 at each later cpv falling edge, ending at N; there is no wrap-around.
REQ-026 After the final PULSE_LO the FSM SHALL enter READY, so that row_ready = 1 from cycle 1+H+2(N+1)H.
REQ-027 In READY, oe SHALL equal gate_on delayed by one cycle; outside READY, oe SHALL be 0, and gate_on outside READY SHALL be ignored.
REQ-028 READY SHALL exit to DONE on the first cycle gate_on is low after having been sampled high in READY; gate_on already high on READY entry counts as sampled high.
REQ-029 DONE SHALL last one cycle (row_ready = 0, oe = 0) and then enter IDLE; busy SHALL fall on the cycle after DONE.
REQ-030 abort high in any non-IDLE state SHALL force IDLE next cycle, with stv, cpv, oe, row_ready and busy at 0 and cur_row holding its value.
REQ-031 abort coincident with row_req in IDLE SHALL take priority, and the request SHALL be dropped.
REQ-032 cur_row SHALL hold its last value in IDLE and SHALL be cleared only on rst.

Reset
REQ-033 When rst is asserted, the block SHALL immediately enter IDLE and clear all counters and all outputs (stv, cpv, oe, busy, row_ready, addr_err = 0; cur_row = 0).
REQ-034 Reset asserted mid-operation SHALL abandon the sequence with no completion indication.

Configuration
REQ-035 With GATE_SEQ_OE_GUARD_EN defined, GUARD SHALL be inserted between the last PULSE_LO and READY for OE_GUARD cycles with oe = 0, delaying row_ready by OE_GUARD cycles; abort SHALL apply in GUARD.
REQ-036 Without GATE_SEQ_OE_GUARD_EN, GUARD SHALL be absent, PULSE_LO SHALL go directly to READY, and the OE_GUARD parameter SHALL be unused.

Verification (H = 4, OE_GUARD = 20)
REQ-037 Scenario: row_req with row_addr = 2, macro undefined -> stv high cycles 1-8; cpv high cycles 5-8, 13-16 and 21-24; row_ready = 1 at cycle 29; cur_row = 2.
REQ-038 Scenario: same stimulus as REQ-037 with macro defined -> row_ready = 1 at cycle 49; oe = 0 throughout cycles 29-48.
REQ-039 Scenario: in READY, gate_on high for 10 cycles then low -> oe high for 10 cycles lagging gate_on by 1 cycle; DONE one cycle later; busy low the cycle after DONE.
REQ-040 Scenario: row_req with row_addr = MAX_ROWS -> addr_err pulse at cycle 1 only; busy, stv and cpv stay 0.
REQ-041 Scenario: abort at cycle 14 of a row_addr = 5 request -> cycle 15 all outputs 0 and busy = 0; cur_row = 0 retained; a new row_req is then accepted.
REQ-042 Scenario: rst asserted mid-PULSE_HI -> immediate return to IDLE with all outputs 0 and cur_row = 0; row_addr = 0 request afterwards -> exactly one cpv pulse, row_ready at cycle 13.
